// File: rtl/mod_down_counter.sv
// -----------------------------------------------------------------------------
// mod_down_counter
//
// Loadable modulo-(MAX+1) binary down counter with a count enable, a one-shot
// mode that parks in a DONE state, and registered terminal-count and wrap
// pulses. It is the countdown/timer companion to the 3-bit up counter. With
// the default parameters it free-runs 0,7,6,...,1,0,7.
//
// Parameters:
//   WIDTH    counter width in bits
//   MAX      reload/wrap value, 1 <= MAX <= 2^WIDTH-1
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   en        in   count enable, one decrement per enabled edge
//   load      in   synchronous load strobe; outranks en
//   load_val  in   value captured on load; values above MAX clamp to MAX
//   mode      in   0 = wrap (free-running), 1 = one-shot (stop in DONE)
//   count     out  current count, registered
//   zero      out  combinational, count == 0
//   tc        out  registered one-cycle pulse on the edge that takes 1 -> 0
//   wrap      out  registered one-cycle pulse on the edge that takes 0 -> MAX
//   done      out  high while the FSM sits in DONE; also serves as the
//                  observable FSM state (RUN = 0, DONE = 1)
//
// Handshake: there is no valid/ready pairing here. load and en are sampled
// level strobes on every rising edge; load has priority over en, en over hold.
// -----------------------------------------------------------------------------
module mod_down_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             wrap_nxt;

  // State register: FSM state plus the registered datapath outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      count <= '0;
      tc    <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tc    <= tc_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Next-state logic. Pulses default low so every branch that does not
  // explicitly raise one produces a single-cycle pulse at most.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    wrap_nxt  = 1'b0;

    if (load) begin
      // Clamp so a non-power-of-2 modulus never holds an out-of-range value.
      count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
      state_nxt = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (en) begin
            if (count != '0) begin
              count_nxt = count - ONE_V;
              tc_nxt    = (count == ONE_V);
            end else if (!mode) begin
              count_nxt = MAX_V;
              wrap_nxt  = 1'b1;
            end else begin
              state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Parked at zero; en is ignored. Leaving one-shot mode releases
          // the FSM back to RUN without touching the count, so the next
          // enabled edge performs the usual wrap to MAX.
          count_nxt = '0;
          if (!mode) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    zero = (count == '0);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_mod_down_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_down_counter
//
// Two instances share one set of inputs: u_dut7 with the default modulus
// (WIDTH=3, MAX=7) and u_dut5 with a non-power-of-2 modulus (WIDTH=3, MAX=5).
// A behavioural model per instance predicts count/zero/tc/wrap/done from the
// counter's rules using integer arithmetic; directed steps follow the test
// plan, then a randomized phase mixes loads, enables, mode changes and
// asynchronous resets.
// -----------------------------------------------------------------------------
module tb_mod_down_counter;

  // ---------------------------------------------------------------- clock/reset
  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [2:0] load_val;
  logic       mode;

  logic [2:0] count7, count5;
  logic       zero7, zero5;
  logic       tc7, tc5;
  logic       wrap7, wrap5;
  logic       done7, done5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_down_counter #(.WIDTH(3), .MAX(7)) u_dut7 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .count    (count7),
    .zero     (zero7),
    .tc       (tc7),
    .wrap     (wrap7),
    .done     (done7)
  );

  mod_down_counter #(.WIDTH(3), .MAX(5)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .count    (count5),
    .zero     (zero5),
    .tc       (tc5),
    .wrap     (wrap5),
    .done     (done5)
  );

  // ---------------------------------------------------------------- model
  // Index 0 models the MAX=7 instance, index 1 the MAX=5 instance.
  int m_max  [2] = '{7, 5};
  int m_cnt  [2];
  bit m_done [2];
  bit m_tc   [2];
  bit m_wrap [2];

  int n_vec = 0;
  int n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_done[i] = 1'b0;
      m_tc[i]   = 1'b0;
      m_wrap[i] = 1'b0;
    end
  endfunction

  // One rising edge of the counter's rules, using the inputs held at the edge.
  function automatic void model_edge();
    int lv;
    lv = int'(load_val);
    for (int i = 0; i < 2; i++) begin
      m_tc[i]   = 1'b0;
      m_wrap[i] = 1'b0;
      if (load) begin
        m_cnt[i]  = (lv > m_max[i]) ? m_max[i] : lv;
        m_done[i] = 1'b0;
      end else if (m_done[i]) begin
        m_cnt[i] = 0;
        if (!mode) m_done[i] = 1'b0;
      end else if (en) begin
        if (m_cnt[i] == 0 && mode) begin
          m_done[i] = 1'b1;
        end else begin
          m_tc[i]   = (m_cnt[i] == 1);
          m_wrap[i] = (m_cnt[i] == 0);
          // Counting down modulo (MAX+1): subtract one, borrow from MAX+1.
          m_cnt[i]  = (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " count7"}, 32'(count7), 32'(m_cnt[0]));
    chk({tag, " zero7"},  32'(zero7),  32'(m_cnt[0] == 0));
    chk({tag, " tc7"},    32'(tc7),    32'(m_tc[0]));
    chk({tag, " wrap7"},  32'(wrap7),  32'(m_wrap[0]));
    chk({tag, " done7"},  32'(done7),  32'(m_done[0]));
    chk({tag, " count5"}, 32'(count5), 32'(m_cnt[1]));
    chk({tag, " zero5"},  32'(zero5),  32'(m_cnt[1] == 0));
    chk({tag, " tc5"},    32'(tc5),    32'(m_tc[1]));
    chk({tag, " wrap5"},  32'(wrap5),  32'(m_wrap[1]));
    chk({tag, " done5"},  32'(done5),  32'(m_done[1]));
  endtask

  // ---------------------------------------------------------------- drivers
  // Apply the currently driven inputs across one rising edge, then check
  // 1 time unit later. Inputs change only after the check.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic e, input logic l, input logic [2:0] lv, input logic m);
    en       = e;
    load     = l;
    load_val = lv;
    mode     = m;
  endtask

  // Pulse reset between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  int seq7 [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
  int seq5 [10] = '{5, 4, 3, 2, 1, 0, 5, 4, 3, 2};

  initial begin
    rst = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    #10;
    rst = 1'b1;

    // Free-running wrap from reset.
    set_in(1'b1, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("free_run");
      chk("free_run seq7", 32'(count7), 32'(seq7[k]));
      chk("free_run seq5", 32'(count5), 32'(seq5[k]));
    end

    // One-shot countdown from 3 into DONE.
    set_in(1'b0, 1'b1, 3'd3, 1'b1);
    step("oneshot_load");
    set_in(1'b1, 1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 6; k++) step("oneshot_run");
    chk("oneshot parked", 32'(done7), 32'd1);

    // en ignored in DONE; load beats en in the same cycle.
    for (int k = 0; k < 3; k++) step("done_en");
    set_in(1'b1, 1'b1, 3'd2, 1'b1);
    step("done_load");
    chk("done_load count", 32'(count7), 32'd2);
    set_in(1'b1, 1'b0, 3'd0, 1'b1);
    step("after_load_1");
    step("after_load_0");

    // Clamped load on the MAX=5 instance, then wrap to 5.
    set_in(1'b0, 1'b1, 3'd7, 1'b0);
    step("clamp_load");
    chk("clamp count5", 32'(count5), 32'd5);
    set_in(1'b1, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 6; k++) step("clamp_run");

    // Asynchronous reset mid-count at 4, then wrap from 0.
    set_in(1'b0, 1'b1, 3'd6, 1'b0);
    step("pre_rst_load");
    set_in(1'b1, 1'b0, 3'd0, 1'b0);
    step("pre_rst_5");
    step("pre_rst_4");
    async_reset("mid_reset");
    step("post_reset");
    chk("post_reset wrap7", 32'(wrap7), 32'd1);

    // en toggling from 2: tc only on the first zero cycle.
    set_in(1'b0, 1'b1, 3'd2, 1'b0);
    step("toggle_load");
    for (int k = 0; k < 4; k++) begin
      en = (k % 2 == 0);
      step("toggle");
    end

    // DONE released by mode=0, then the next enabled edge wraps.
    set_in(1'b1, 1'b1, 3'd1, 1'b1);
    step("rel_load");
    set_in(1'b1, 1'b0, 3'd0, 1'b1);
    step("rel_to_0");
    step("rel_to_done");
    set_in(1'b0, 1'b0, 3'd0, 1'b0);
    step("rel_to_run");
    set_in(1'b1, 1'b0, 3'd0, 1'b0);
    step("rel_wrap");

    // Randomized phase.
    for (int k = 0; k < 400; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 63) == 0) async_reset("rand_reset");
      else step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
